// File: rtl/lab_hold_scheduler.sv
// Queues LAB hold buffers in HOLD-edge order and sequences digitize/ready/release.
// Optional digitize timeout: define LAB_DIGITIZE_TIMEOUT_EN.
module lab_hold_scheduler #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd33000
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [3:0] hold_i,
  input  logic       done_i,
  input  logic [3:0] release_i,
  input  logic       clr_flags_i,
  output logic [3:0] digitize_o,
  output logic       ready_o,
  output logic [1:0] ready_buf_o,
  output logic [3:0] held_o,
  output logic       busy_o,
  output logic       overrun_o,
  output logic       timeout_o
);

  typedef enum logic [1:0] {IDLE, WAIT_DONE, READY} state_t;

  state_t     state_q, state_d;
  logic [3:0] hold_q, pending_q, rise;
  logic [3:0] push_oh, free_mask;
  logic [1:0] fifo_q [4];
  logic [1:0] wr_q, rd_q, cur_q, push_idx;
  logic [2:0] cnt_q;
  logic       push, pop, fin_done, fin_rel, fin_tmo, tmo_hit;

  assign rise = hold_i & ~hold_q;

  always_comb begin
    push     = |pending_q;
    push_idx = 2'd0;
    priority case (1'b1)
      pending_q[0]: push_idx = 2'd0;
      pending_q[1]: push_idx = 2'd1;
      pending_q[2]: push_idx = 2'd2;
      pending_q[3]: push_idx = 2'd3;
      default:      push_idx = 2'd0;
    endcase
    push_oh = push ? (4'b0001 << push_idx) : 4'b0000;
  end

  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    fin_done = 1'b0;
    fin_rel  = 1'b0;
    fin_tmo  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cnt_q != 3'd0) begin
          pop     = 1'b1;
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        // done on the expiry cycle still takes the normal path
        if (done_i) begin
          fin_done = 1'b1;
          state_d  = READY;
        end else if (tmo_hit) begin
          fin_tmo = 1'b1;
          state_d = IDLE;
        end
      end
      READY: begin
        if (release_i[cur_q]) begin
          fin_rel = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    free_mask = (fin_rel | fin_tmo) ? (4'b0001 << cur_q) : 4'b0000;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      hold_q      <= '0;
      pending_q   <= '0;
      held_o      <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      cur_q       <= '0;
      digitize_o  <= '0;
      ready_o     <= 1'b0;
      ready_buf_o <= '0;
      busy_o      <= 1'b0;
      overrun_o   <= 1'b0;
      for (int i = 0; i < 4; i++) fifo_q[i] <= '0;
    end else begin
      hold_q    <= hold_i;
      // a rise on a buffer being released this cycle is an overrun
      held_o    <= (held_o | rise) & ~free_mask;
      pending_q <= (pending_q & ~push_oh) | (rise & ~held_o);
      if (push) begin
        fifo_q[wr_q] <= push_idx;
        wr_q         <= wr_q + 2'd1;
      end
      if (pop) begin
        cur_q      <= fifo_q[rd_q];
        rd_q       <= rd_q + 2'd1;
        digitize_o <= 4'b0001 << fifo_q[rd_q];
      end
      cnt_q <= cnt_q + {2'b00, push} - {2'b00, pop};
      if (fin_done) begin
        digitize_o  <= '0;
        ready_o     <= 1'b1;
        ready_buf_o <= cur_q;
      end
      if (fin_tmo) digitize_o <= '0;
      if (fin_rel) ready_o <= 1'b0;
      busy_o    <= &held_o;
      overrun_o <= (overrun_o & ~clr_flags_i) | (|(rise & held_o));
    end
  end

`ifdef LAB_DIGITIZE_TIMEOUT_EN
  logic [15:0] tcnt_q;

  assign tmo_hit = (tcnt_q == TIMEOUT_CYCLES - 16'd1);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      tcnt_q    <= '0;
      timeout_o <= 1'b0;
    end else begin
      if (pop)                        tcnt_q <= '0;
      else if (state_q == WAIT_DONE)  tcnt_q <= tcnt_q + 16'd1;
      timeout_o <= (timeout_o & ~clr_flags_i) | fin_tmo;
    end
  end
`else
  logic unused_tmo;

  assign tmo_hit    = 1'b0;
  assign timeout_o  = 1'b0;
  assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

endmodule
